// File: rtl/game_pkg.sv
// Shared encodings and widths for the fight-round logic in the clk_game domain.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned HEALTH_W = 7;
  localparam int unsigned STUN_W   = 8;
  localparam int unsigned TIMER_W  = 8;
  localparam int unsigned GEOM_W   = 12;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_STARTUP  = 2'd1,
    PH_ACTIVE   = 2'd2,
    PH_RECOVERY = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ST_ATTRACT    = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_KO         = 3'd3,
    ST_MATCH_OVER = 3'd4
  } ref_state_e;

endpackage

// File: rtl/hit_resolver.sv
// Resolves one attacker's hits against one victim: one-hit-per-attack flag,
// block decision, saturating health and stun countdown.
module hit_resolver
  import game_pkg::*;
#(
  parameter int unsigned HEALTH_MAX = 100,
  parameter int unsigned DAMAGE     = 10,
  parameter int unsigned REACH      = 24,
  parameter int unsigned HITSTUN    = 12,
  parameter int unsigned BLOCKSTUN  = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                fight_i,
  input  logic                reload_i,
  input  logic [1:0]          atk_phase_i,
  input  logic [1:0]          vic_phase_i,
  input  logic                vic_back_i,
  input  logic [9:0]          left_x_i,
  input  logic [9:0]          left_w_i,
  input  logic [9:0]          right_x_i,
  output logic [HEALTH_W-1:0] health_o,
  output logic                stunned_o,
  output logic                hit_pulse_o
);

  logic [GEOM_W-1:0]   reach_edge;
  logic                in_range, atk_active, blocked, hit;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [STUN_W-1:0]   stun_q, stun_d;
  logic                done_q, done_d, pulse_q, pulse_d;

  // Both attack directions reduce to the same test: P2's left edge lies
  // within REACH of P1's right edge. 12-bit sums cannot wrap.
  assign reach_edge = GEOM_W'(left_x_i) + GEOM_W'(left_w_i) + GEOM_W'(REACH);
  assign in_range   = GEOM_W'(right_x_i) < reach_edge;
  assign atk_active = (atk_phase_i == PH_ACTIVE);
  assign blocked    = vic_back_i && (vic_phase_i == PH_IDLE);
  assign hit        = fight_i && atk_active && in_range && !done_q;

  always_comb begin
    health_d = health_q;
    stun_d   = stun_q;
    done_d   = atk_active ? done_q : 1'b0;
    pulse_d  = hit;
    if (fight_i && stun_q != '0) stun_d = stun_q - STUN_W'(1);
    if (hit) begin
      done_d = 1'b1;
      if (blocked) begin
        stun_d = STUN_W'(BLOCKSTUN);
      end else begin
        stun_d   = STUN_W'(HITSTUN);
        health_d = (health_q > HEALTH_W'(DAMAGE)) ? health_q - HEALTH_W'(DAMAGE) : '0;
      end
    end
    if (reload_i) begin
      health_d = HEALTH_W'(HEALTH_MAX);
      stun_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      health_q <= HEALTH_W'(HEALTH_MAX);
      stun_q   <= '0;
      done_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      health_q <= health_d;
      stun_q   <= stun_d;
      done_q   <= done_d;
      pulse_q  <= pulse_d;
    end
  end

  assign health_o    = health_q;
  assign stunned_o   = (stun_q != '0);
  assign hit_pulse_o = pulse_q;

endmodule

// File: rtl/combat_referee.sv
// Match-level referee: round flow FSM, round/winner bookkeeping and freeze
// gating, with per-victim hit resolution in two hit_resolver instances.
module combat_referee
  import game_pkg::*;
#(
  parameter int unsigned HEALTH_MAX       = 100,
  parameter int unsigned DAMAGE           = 10,
  parameter int unsigned REACH            = 24,
  parameter int unsigned HITSTUN          = 12,
  parameter int unsigned BLOCKSTUN        = 8,
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned KO_FRAMES        = 120,
  parameter int unsigned ROUNDS_TO_WIN    = 2
) (
  input  logic                clk_game,
  input  logic                reset,
  input  logic                start_btn,
  input  logic [9:0]          p1_x_pos,
  input  logic [9:0]          p2_x_pos,
  input  logic [9:0]          p1_width,
  input  logic [9:0]          p2_width,
  input  logic [1:0]          p1_phase,
  input  logic [1:0]          p2_phase,
  input  logic                p1_back_held,
  input  logic                p2_back_held,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic [1:0]          p1_rounds,
  output logic [1:0]          p2_rounds,
  output logic                p1_freeze,
  output logic                p2_freeze,
  output logic                p1_hit_pulse,
  output logic                p2_hit_pulse,
  output logic                round_reset,
  output logic [2:0]          round_state,
  output logic [1:0]          winner
);

  ref_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         p1r_q, p1r_d, p2r_q, p2r_d, winner_q, winner_d;
  logic               round_reset_q, start_q, start_rise, enter_cd, fight;
  logic               p1_stunned, p2_stunned;
  logic               unused_p2_width;

  // P2's hitbox extends leftward from its left edge, so its width never matters.
  assign unused_p2_width = ^p2_width;
  assign start_rise      = start_btn && !start_q;
  assign fight           = (state_q == ST_FIGHT);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TIMER_W'(1);
    p1r_d    = p1r_q;
    p2r_d    = p2r_q;
    winner_d = winner_q;
    case (state_q)
      ST_ATTRACT:   if (start_rise) state_d = ST_COUNTDOWN;
      ST_COUNTDOWN: if (timer_q == TIMER_W'(COUNTDOWN_FRAMES - 1)) state_d = ST_FIGHT;
      ST_FIGHT:     if (p1_health == '0 || p2_health == '0) state_d = ST_KO;
      ST_KO: begin
        if (timer_q == '0) begin
          if (p1_health == '0 && p2_health != '0) p2r_d = p2r_q + 2'd1;
          else if (p2_health == '0 && p1_health != '0) p1r_d = p1r_q + 2'd1;
        end
        if (timer_q == TIMER_W'(KO_FRAMES - 1)) begin
          if (p1r_d == 2'(ROUNDS_TO_WIN) || p2r_d == 2'(ROUNDS_TO_WIN)) begin
            state_d  = ST_MATCH_OVER;
            winner_d = (p1r_d > p2r_d) ? 2'd1 : (p2r_d > p1r_d) ? 2'd2 : 2'd3;
          end else begin
            state_d = ST_COUNTDOWN;
          end
        end
      end
      ST_MATCH_OVER: begin
        if (start_rise) begin
          state_d  = ST_COUNTDOWN;
          p1r_d    = '0;
          p2r_d    = '0;
          winner_d = '0;
        end
      end
      default: state_d = ST_ATTRACT;
    endcase
    if (state_d != state_q) timer_d = '0;
    enter_cd = (state_d == ST_COUNTDOWN) && (state_q != ST_COUNTDOWN);
  end

  always_ff @(posedge clk_game) begin
    if (reset) begin
      state_q       <= ST_ATTRACT;
      timer_q       <= '0;
      p1r_q         <= '0;
      p2r_q         <= '0;
      winner_q      <= '0;
      round_reset_q <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      p1r_q         <= p1r_d;
      p2r_q         <= p2r_d;
      winner_q      <= winner_d;
      round_reset_q <= enter_cd;
      start_q       <= start_btn;
    end
  end

  hit_resolver #(
    .HEALTH_MAX(HEALTH_MAX), .DAMAGE(DAMAGE), .REACH(REACH),
    .HITSTUN(HITSTUN), .BLOCKSTUN(BLOCKSTUN)
  ) u_hit_on_p2 (
    .clk_i(clk_game), .reset_i(reset), .fight_i(fight), .reload_i(enter_cd),
    .atk_phase_i(p1_phase), .vic_phase_i(p2_phase), .vic_back_i(p2_back_held),
    .left_x_i(p1_x_pos), .left_w_i(p1_width), .right_x_i(p2_x_pos),
    .health_o(p2_health), .stunned_o(p2_stunned), .hit_pulse_o(p2_hit_pulse)
  );

  hit_resolver #(
    .HEALTH_MAX(HEALTH_MAX), .DAMAGE(DAMAGE), .REACH(REACH),
    .HITSTUN(HITSTUN), .BLOCKSTUN(BLOCKSTUN)
  ) u_hit_on_p1 (
    .clk_i(clk_game), .reset_i(reset), .fight_i(fight), .reload_i(enter_cd),
    .atk_phase_i(p2_phase), .vic_phase_i(p1_phase), .vic_back_i(p1_back_held),
    .left_x_i(p1_x_pos), .left_w_i(p1_width), .right_x_i(p2_x_pos),
    .health_o(p1_health), .stunned_o(p1_stunned), .hit_pulse_o(p1_hit_pulse)
  );

  assign p1_freeze   = !fight || p1_stunned;
  assign p2_freeze   = !fight || p2_stunned;
  assign p1_rounds   = p1r_q;
  assign p2_rounds   = p2r_q;
  assign winner      = winner_q;
  assign round_reset = round_reset_q;
  assign round_state = state_q;

endmodule

// File: tb/tb_combat_referee.sv
// Directed round-flow scenarios plus randomized play, checked every frame
// against a behavioural model of the referee rules.
module tb_combat_referee;
  import game_pkg::*;

  localparam int HMAX = 100, DMG = 10, RCH = 24, HS = 12, BS = 8;
  localparam int CDF = 180, KOF = 120, RTW = 2;

  logic       clk_game = 1'b0;
  logic       reset, start_btn, p1_back_held, p2_back_held;
  logic [9:0] p1_x_pos, p2_x_pos, p1_width, p2_width;
  logic [1:0] p1_phase, p2_phase;
  logic [6:0] p1_health, p2_health;
  logic [1:0] p1_rounds, p2_rounds, winner;
  logic       p1_freeze, p2_freeze, p1_hit_pulse, p2_hit_pulse, round_reset;
  logic [2:0] round_state;

  always #5 clk_game = ~clk_game;

  combat_referee #(
    .HEALTH_MAX(HMAX), .DAMAGE(DMG), .REACH(RCH), .HITSTUN(HS), .BLOCKSTUN(BS),
    .COUNTDOWN_FRAMES(CDF), .KO_FRAMES(KOF), .ROUNDS_TO_WIN(RTW)
  ) dut (
    .clk_game(clk_game), .reset(reset), .start_btn(start_btn),
    .p1_x_pos(p1_x_pos), .p2_x_pos(p2_x_pos), .p1_width(p1_width), .p2_width(p2_width),
    .p1_phase(p1_phase), .p2_phase(p2_phase),
    .p1_back_held(p1_back_held), .p2_back_held(p2_back_held),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
    .p1_freeze(p1_freeze), .p2_freeze(p2_freeze),
    .p1_hit_pulse(p1_hit_pulse), .p2_hit_pulse(p2_hit_pulse),
    .round_reset(round_reset), .round_state(round_state), .winner(winner)
  );

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model, index 0 = P1, 1 = P2; done[] is indexed by attacker.
  int m_state, m_frames, m_win, m_rr, m_start_prev;
  int m_h[2], m_r[2], m_stun[2], m_done[2], m_pulse[2];

  task automatic model_reset();
    m_state = 0; m_frames = 0; m_win = 0; m_rr = 0; m_start_prev = 0;
    for (int i = 0; i < 2; i++) begin
      m_h[i] = HMAX; m_r[i] = 0; m_stun[i] = 0; m_done[i] = 0; m_pulse[i] = 0;
    end
  endtask

  task automatic model_step();
    int ph[2], back[2], hit[2], n_h[2], n_stun[2], n_done[2], n_r[2];
    int n_state, n_win, fight, rise, reach;
    if (reset) begin
      model_reset();
      return;
    end
    ph[0] = int'(p1_phase); ph[1] = int'(p2_phase);
    back[0] = int'(p1_back_held); back[1] = int'(p2_back_held);
    rise  = (start_btn && m_start_prev == 0) ? 1 : 0;
    fight = (m_state == 2) ? 1 : 0;
    reach = (int'(p2_x_pos) < int'(p1_x_pos) + int'(p1_width) + RCH) ? 1 : 0;
    for (int v = 0; v < 2; v++) begin
      hit[v] = (fight == 1 && ph[1-v] == 2 && reach == 1 && m_done[1-v] == 0) ? 1 : 0;
      n_h[v] = m_h[v];
      n_stun[v] = (fight == 1 && m_stun[v] > 0) ? m_stun[v] - 1 : m_stun[v];
      if (hit[v] == 1) begin
        if (back[v] == 1 && ph[v] == 0) n_stun[v] = BS;
        else begin
          n_stun[v] = HS;
          n_h[v] = (m_h[v] > DMG) ? m_h[v] - DMG : 0;
        end
      end
    end
    for (int a = 0; a < 2; a++)
      n_done[a] = (ph[a] == 2) ? ((m_done[a] == 1 || hit[1-a] == 1) ? 1 : 0) : 0;
    n_state = m_state; n_r = m_r; n_win = m_win;
    case (m_state)
      0: if (rise == 1) n_state = 1;
      1: if (m_frames == CDF - 1) n_state = 2;
      2: if (m_h[0] == 0 || m_h[1] == 0) n_state = 3;
      3: begin
        if (m_frames == 0) begin
          if (m_h[0] == 0 && m_h[1] != 0) n_r[1]++;
          if (m_h[1] == 0 && m_h[0] != 0) n_r[0]++;
        end
        if (m_frames == KOF - 1) begin
          if (n_r[0] == RTW || n_r[1] == RTW) begin
            n_state = 4;
            n_win = (n_r[0] > n_r[1]) ? 1 : (n_r[1] > n_r[0]) ? 2 : 3;
          end else n_state = 1;
        end
      end
      4: if (rise == 1) begin n_state = 1; n_r[0] = 0; n_r[1] = 0; n_win = 0; end
      default: n_state = 0;
    endcase
    m_rr = (n_state == 1 && m_state != 1) ? 1 : 0;
    if (m_rr == 1) begin
      n_h[0] = HMAX; n_h[1] = HMAX; n_stun[0] = 0; n_stun[1] = 0;
    end
    m_frames = (n_state != m_state) ? 0 : m_frames + 1;
    m_state = n_state; m_win = n_win; m_r = n_r;
    m_h = n_h; m_stun = n_stun; m_done = n_done; m_pulse = hit;
    m_start_prev = int'(start_btn);
  endtask

  task automatic compare_all();
    chk("state", int'(round_state), m_state);
    chk("p1_health", int'(p1_health), m_h[0]);
    chk("p2_health", int'(p2_health), m_h[1]);
    chk("p1_rounds", int'(p1_rounds), m_r[0]);
    chk("p2_rounds", int'(p2_rounds), m_r[1]);
    chk("p1_freeze", int'(p1_freeze), (m_state != 2 || m_stun[0] != 0) ? 1 : 0);
    chk("p2_freeze", int'(p2_freeze), (m_state != 2 || m_stun[1] != 0) ? 1 : 0);
    chk("p1_hit_pulse", int'(p1_hit_pulse), m_pulse[0]);
    chk("p2_hit_pulse", int'(p2_hit_pulse), m_pulse[1]);
    chk("round_reset", int'(round_reset), m_rr);
    chk("winner", int'(winner), m_win);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_game);
    #1;
    compare_all();
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int n = 0;
    while (int'(round_state) != st && n < budget) begin
      tick();
      n++;
    end
    if (int'(round_state) != st) chk(tag, int'(round_state), st);
  endtask

  task automatic p1_strike();
    p1_phase = 2'd2; tick();
    p1_phase = 2'd0; tick();
  endtask

  task automatic p2_strike();
    p2_phase = 2'd2; tick();
    p2_phase = 2'd0; tick();
  endtask

  task automatic press_start();
    start_btn = 1'b1; tick();
    start_btn = 1'b0;
  endtask

  // P1 active for 3 frames then idle for 15; counts P2 pulses and frozen frames.
  task automatic p1_window(output int pulses, output int frz);
    pulses = 0; frz = 0;
    for (int i = 0; i < 18; i++) begin
      p1_phase = (i < 3) ? 2'd2 : 2'd0;
      tick();
      pulses += int'(p2_hit_pulse);
      frz += int'(p2_freeze);
    end
  endtask

  task automatic home_positions();
    p1_x_pos = 10'd200; p1_width = 10'd32; p2_x_pos = 10'd250; p2_width = 10'd32;
    p1_phase = 2'd0; p2_phase = 2'd0; p1_back_held = 1'b0; p2_back_held = 1'b0;
  endtask

  initial begin
    int cnt, extra, pulses, frz, n;
    reset = 1'b1; start_btn = 1'b0;
    home_positions();
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_state", int'(round_state), 0);
    chk("rst_p1_health", int'(p1_health), HMAX);
    chk("rst_p2_freeze", int'(p2_freeze), 1);
    chk("rst_winner", int'(winner), 0);

    // Countdown length and single round_reset pulse
    press_start();
    chk("cd_round_reset", int'(round_reset), 1);
    cnt = 0; extra = 0;
    while (int'(round_state) != 2 && cnt < 400) begin
      tick();
      cnt++;
      extra += int'(round_reset);
    end
    chk("cd_length", cnt, CDF);
    chk("cd_rr_once", extra, 0);
    chk("fight_p1_freeze", int'(p1_freeze), 0);
    chk("fight_p2_freeze", int'(p2_freeze), 0);

    p1_window(pulses, frz);
    chk("hit_pulses", pulses, 1);
    chk("hit_health", int'(p2_health), 90);
    chk("hit_freeze_len", frz, HS);

    p2_x_pos = 10'd257;
    p1_window(pulses, frz);
    chk("reach_257_pulses", pulses, 0);
    p2_x_pos = 10'd256;
    p1_window(pulses, frz);
    chk("reach_256_pulses", pulses, 0);
    chk("reach_out_health", int'(p2_health), 90);
    p2_x_pos = 10'd255;
    p1_window(pulses, frz);
    chk("reach_255_pulses", pulses, 1);
    chk("reach_in_health", int'(p2_health), 80);

    p2_back_held = 1'b1;
    p1_window(pulses, frz);
    chk("block_pulses", pulses, 1);
    chk("block_health", int'(p2_health), 80);
    chk("block_freeze_len", frz, BS);
    p2_back_held = 1'b0;

    // Trade down to a double KO
    p2_x_pos = 10'd250;
    repeat (7) p1_strike();
    repeat (9) p2_strike();
    chk("pre_trade_p1", int'(p1_health), 10);
    chk("pre_trade_p2", int'(p2_health), 10);
    p1_phase = 2'd2; p2_phase = 2'd2; tick();
    p1_phase = 2'd0; p2_phase = 2'd0;
    chk("trade_p1_pulse", int'(p1_hit_pulse), 1);
    chk("trade_p2_pulse", int'(p2_hit_pulse), 1);
    wait_state(3, 10, "ko_timeout");
    n = 0;
    while (int'(round_state) == 3 && n < 300) begin
      tick();
      n++;
    end
    chk("ko_length", n, KOF);
    chk("dko_state", int'(round_state), 1);
    chk("dko_p1_rounds", int'(p1_rounds), 0);
    chk("dko_p2_rounds", int'(p2_rounds), 0);
    chk("dko_reload", int'(p1_health), HMAX);

    // Random play until a match is decided
    wait_state(2, 400, "rand_fight_timeout");
    n = 0;
    while (int'(round_state) != 4 && n < 30000) begin
      if (n % 16 == 0) begin
        p1_x_pos = 10'($urandom_range(0, SCREEN_W / 2));
        p1_width = 10'($urandom_range(16, 64));
        p2_x_pos = p1_x_pos + 10'($urandom_range(0, 100));
        p2_width = 10'($urandom_range(16, 64));
      end
      p1_phase = 2'($urandom_range(0, 3));
      p2_phase = 2'($urandom_range(0, 3));
      p1_back_held = ($urandom_range(0, 7) == 0);
      p2_back_held = ($urandom_range(0, 7) == 0);
      tick();
      n++;
    end
    if (int'(round_state) != 4) chk("rand_match_timeout", int'(round_state), 4);

    // P1 wins two straight rounds
    home_positions();
    press_start();
    chk("restart_p1_rounds", int'(p1_rounds), 0);
    chk("restart_winner", int'(winner), 0);
    for (int r = 0; r < 2; r++) begin
      wait_state(2, 500, "p1win_fight_timeout");
      repeat (10) p1_strike();
      wait_state(3, 10, "p1win_ko_timeout");
    end
    wait_state(4, 300, "p1win_over_timeout");
    chk("p1win_winner", int'(winner), 1);
    chk("p1win_p1_rounds", int'(p1_rounds), 2);
    chk("p1win_p2_rounds", int'(p2_rounds), 0);

    // Reset mid-fight discards round progress
    press_start();
    wait_state(2, 500, "rst_fight_timeout");
    repeat (10) p1_strike();
    wait_state(2, 500, "rst_fight2_timeout");
    repeat (3) p1_strike();
    chk("prerst_p1_rounds", int'(p1_rounds), 1);
    chk("prerst_p2_health", int'(p2_health), 70);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("midrst_state", int'(round_state), 0);
    chk("midrst_p2_health", int'(p2_health), HMAX);
    chk("midrst_p1_rounds", int'(p1_rounds), 0);
    chk("midrst_p1_freeze", int'(p1_freeze), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
